bc_fir_window_feeder: RTL and testbench

//  Streaming front/back end for the combinational binary-coded FIR core (BC_FIR).

---
 rtl/bc_fir_pkg.sv | 23 ++
 rtl/bc_fir_delay_line.sv | 31 +++
 rtl/bc_fir_window_feeder.sv | 87 ++++++++
 tb/tb_bc_fir_window_feeder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bc_fir_pkg.sv
// Shared types and sizes for the BC_FIR streaming feeder and its delay line.
package bc_fir_pkg;

    localparam int unsigned W      = 12;
    localparam int unsigned TAPS   = 19;
    localparam int unsigned FILL_W = $clog2(TAPS + 1);

    typedef logic [W-1:0]      sample_t;
    typedef sample_t           win_t [TAPS];
    typedef logic [FILL_W-1:0] fill_t;

    localparam fill_t FILL_FULL = fill_t'(TAPS);
    localparam fill_t FILL_LAST = fill_t'(TAPS - 1);

    // Saturating increment of the priming counter.
    function automatic fill_t fill_inc(input fill_t f);
        if (f >= FILL_FULL) begin
            return FILL_FULL;
        end
        return f + fill_t'(1);
    endfunction

endpackage

// File: rtl/bc_fir_delay_line.sv
// TAPS-deep sample shift register: slot 0 takes the newest sample, slot TAPS-1 holds the oldest.
module bc_fir_delay_line
    import bc_fir_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clr,
    input  logic    en,
    input  sample_t din,
    output win_t    win
);

    win_t win_q;

    // Shift on enable; synchronous reset and clear both zero every slot.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                win_q[i] <= '0;
            end
        end else if (en) begin
            win_q[0] <= din;
            for (int i = 1; i < int'(TAPS); i++) begin
                win_q[i] <= win_q[i-1];
            end
        end
    end

    assign win = win_q;

endmodule

// File: rtl/bc_fir_window_feeder.sv
// Streaming wrapper around the combinational BC_FIR core: feeds the sample window out and
// registers the core result onto a valid/ready output stream.
module bc_fir_window_feeder
    import bc_fir_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output win_t         win,
    input  logic [W-1:0] fir_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    fill_t         fill_q, fill_d;
    logic          pend_q, pend_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;

    logic          accept;
    logic          accept_full;
    logic          cap;

    // Handshake, priming and capture decisions for this cycle.
    always_comb begin
        // A pending window may be captured when the output register is empty or being drained.
        cap         = pend_q & (~out_valid_q | out_ready);
        // The window may only shift once its previous contents have been captured.
        in_ready    = ~pend_q | cap;
        accept      = in_valid & in_ready;
        accept_full = accept & (fill_q >= FILL_LAST);

        fill_d = fill_q;
        if (accept) begin
            fill_d = fill_inc(fill_q);
        end

        pend_d = accept_full | (pend_q & ~cap);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (cap) begin
            out_valid_d = 1'b1;
            out_data_d  = fir_out;
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output register state; flush acts as a lower-priority soft reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q      <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (flush) begin
            fill_q      <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            fill_q      <= fill_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Capture samples the old window while the shift writes the new one on the same edge.
    bc_fir_delay_line u_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (accept),
        .din   (in_data),
        .win   (win)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_bc_fir_window_feeder.sv
// Self-checking bench for bc_fir_window_feeder with a behavioural BC_FIR core beside it.
module tb_bc_fir_window_feeder;
    import bc_fir_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    win_t         win;
    logic [W-1:0] fir_out;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    always #5 clk = ~clk;

    // BC_FIR coefficients, newest tap first (the impulse response).
    localparam int COEF [TAPS] = '{999, 0, 888, 0, 777, 0, 666, 0, 555, 444,
                                   555, 0, 666, 0, 777, 0, 888, 0, 999};

    function automatic sample_t fir_calc(input win_t w);
        int acc;
        acc = 0;
        for (int i = 0; i < int'(TAPS); i++) begin
            acc += COEF[i] * int'(w[i]);
        end
        return sample_t'(acc);
    endfunction

    always_comb fir_out = fir_calc(win);

    bc_fir_window_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .win       (win),
        .fir_out   (fir_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    int checks   = 0;
    int failures = 0;

    // Golden model: bench-side sample history and expected result queue.
    win_t    hist;
    int      mfill;
    sample_t expq[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(TAPS); i++) hist[i] = '0;
        mfill = 0;
        expq.delete();
    endtask

    // One clock: drive inputs, observe handshakes just before the edge, return after negedge.
    task automatic step(input logic rst, input logic fl, input logic iv, input sample_t d,
                        input logic ordy, output logic acc);
        logic take;
        sample_t e;
        rst_n     = ~rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        acc  = in_valid & in_ready;
        take = out_valid & out_ready;
        if (rst || fl) begin
            model_clear();
            acc = 1'b0;
        end else begin
            if (take) begin
                if (expq.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("result", int'(out_data), int'(e));
                end
            end
            if (acc) begin
                for (int i = int'(TAPS) - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = d;
                if (mfill < int'(TAPS)) mfill++;
                if (mfill == int'(TAPS)) expq.push_back(fir_calc(hist));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        logic a;
        int n;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 100) begin
            step(1'b0, 1'b0, 1'b0, '0, 1'b1, a);
            n++;
        end
        check("drain_queue_empty", expq.size(), 0);
        check("drain_out_valid", int'(out_valid), 0);
    endtask

    typedef struct {
        logic    rst;
        logic    iv;
        sample_t d;
        logic    ordy;
        logic    e_rdy;
        logic    e_val;
        sample_t e_data;
    } vec_t;

    vec_t tbl[$];
    int   imp [TAPS] = '{999, 0, 888, 0, 777, 0, 666, 0, 555, 444,
                         555, 0, 666, 0, 777, 0, 888, 0, 999};

    initial begin
        logic a;
        int   cnt;
        int   sent;
        int   cyc;
        int   bad;
        sample_t held;
        sample_t v;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_clear();
        @(negedge clk);

        // Reset held two cycles while a sample is offered.
        step(1'b1, 1'b0, 1'b1, 12'd77, 1'b0, a);
        step(1'b1, 1'b0, 1'b1, 12'd77, 1'b0, a);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        bad = 0;
        for (int i = 0; i < int'(TAPS); i++) if (win[i] != '0) bad++;
        check("reset_win_zero", bad, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("reset_in_ready", int'(in_ready), 1);

        // Vector table: impulse response then step with modular wrap.
        for (int k = 0; k < 2; k++) tbl.push_back('{1'b1, 1'b1, '0, 1'b1, 1'b1, 1'b0, '0});
        for (int s = 1; s <= 39; s++) begin
            tbl.push_back('{1'b0, (s <= 37), ((s == 19) ? 12'd1 : 12'd0), 1'b1, 1'b1,
                            (s >= 20 && s <= 38),
                            ((s < 20) ? 12'd0 : ((s <= 38) ? sample_t'(imp[s-20]) : 12'd999))});
        end
        tbl.push_back('{1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0});
        for (int s = 1; s <= 22; s++) begin
            tbl.push_back('{1'b0, (s <= 20), 12'd1, 1'b1, 1'b1, (s == 20 || s == 21),
                            ((s < 20) ? 12'd0 : 12'd22)});
        end
        foreach (tbl[i]) begin
            step(tbl[i].rst, 1'b0, tbl[i].iv, tbl[i].d, tbl[i].ordy, a);
            check($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_val));
            check($sformatf("tbl%0d_out_data", i), int'(out_data), int'(tbl[i].e_data));
        end

        // Backpressure after priming: one extra accept, then full stall with held output.
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, a);
        for (int i = 0; i < int'(TAPS); i++) step(1'b0, 1'b0, 1'b1, sample_t'(100 + 37 * i), 1'b1, a);
        cnt = 0;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, sample_t'(2000 + i), 1'b0, a);
            if (a) cnt++;
            if (i == 0) held = out_data;
        end
        check("bp_extra_accepts", cnt, 1);
        check("bp_in_ready_low", int'(in_ready), 0);
        check("bp_out_valid_held", int'(out_valid), 1);
        check("bp_out_data_held", int'(out_data), int'(held));
        check("bp_win_held", int'(win[0]), int'(hist[0]));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, sample_t'(3000 + 11 * i), 1'b1, a);
        drain();

        // Flush while a result is held under backpressure.
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, a);
        for (int i = 0; i < int'(TAPS); i++) step(1'b0, 1'b0, 1'b1, sample_t'(50 + 3 * i), 1'b1, a);
        step(1'b0, 1'b0, 1'b1, 12'd999, 1'b0, a);
        check("fl_pre_out_valid", int'(out_valid), 1);
        step(1'b0, 1'b1, 1'b1, 12'd5, 1'b0, a);
        check("fl_out_valid_cleared", int'(out_valid), 0);
        check("fl_out_data_cleared", int'(out_data), 0);
        cnt = 0;
        for (int i = 0; i < int'(TAPS) - 1; i++) begin
            step(1'b0, 1'b0, 1'b1, sample_t'(400 + 7 * i), 1'b1, a);
            if (out_valid) cnt++;
        end
        check("fl_priming_no_result", cnt, 0);
        step(1'b0, 1'b0, 1'b1, 12'd4000, 1'b1, a);
        check("fl_19th_no_result_yet", int'(out_valid), 0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, a);
        check("fl_first_result", int'(out_valid), 1);
        drain();

        // Random valid/ready toggling against the golden model.
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, a);
        sent = 0;
        cyc  = 0;
        while (sent < 2000 && cyc < 20000) begin
            v = sample_t'($urandom_range(0, 4095));
            step(1'b0, 1'b0, ($urandom_range(0, 9) < 7), v, ($urandom_range(0, 9) < 7), a);
            if (a) sent++;
            cyc++;
        end
        check("rand_samples_sent", sent, 2000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
